uart_responder: RTL and testbench

- Device-side end of the CPU's serial-port bus handshake (rdn/wrn strobes, data_ready/tbre/tsre status, 8-bit data lane on the shared RAM1 data bus).
- Lets the data-memory stage talk to a serial line without the external CPLD: it accepts CPU writes and serializes them onto txd (8N1), and it deserializes rxd into a receive buffer the CPU reads back.
- Sits in the top level beside the data-memory block; bus-side signals connect where the external UART pins connect today.

---
 rtl/uart_responder.sv | 189 ++++++++++++++++++
 tb/tb_uart_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_responder.sv
// Device-side serial port for the CPU bus handshake.
// 8N1 transmitter with holding register plus receiver with single-byte buffer.
module uart_responder #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       wrn,
  input  logic       rdn,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  input  logic       rxd,
  output logic       txd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

  logic       wrn_q, wrn_qq, rdn_q, rdn_qq;
  logic [7:0] cap, hold;
  logic       hold_full;
  logic       wr_rise, rd_rise;

  assign wr_rise = wrn_q & ~wrn_qq;
  assign rd_rise = rdn_q & ~rdn_qq;
  assign data_oe = ~rdn_q;
  assign tbre    = ~hold_full;

  st_t          tx_st, tx_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]   tx_bit, tx_bit_nx;
  logic [7:0]   tx_sh, tx_sh_nx;
  logic         tx_load, txd_nx;

  st_t          rx_st, rx_nx;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]   rx_bit, rx_bit_nx;
  logic [7:0]   rx_sh, rx_sh_nx;
  logic         rx_s1, rx_s2, rx_prev, rx_done;

  assign tsre = (tx_st == IDLE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wrn_q     <= 1'b1;
      wrn_qq    <= 1'b1;
      rdn_q     <= 1'b1;
      rdn_qq    <= 1'b1;
      cap       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      wrn_q  <= wrn;
      wrn_qq <= wrn_q;
      rdn_q  <= rdn;
      rdn_qq <= rdn_q;
      if (!wrn_q) cap <= data_in;
      if (tx_load) hold_full <= 1'b0;
      // a full holding register silently drops the write
      if (wr_rise && !hold_full) begin
        hold      <= cap;
        hold_full <= 1'b1;
      end
    end
  end

  always_comb begin
    tx_nx     = tx_st;
    tx_cnt_nx = tx_cnt;
    tx_bit_nx = tx_bit;
    tx_sh_nx  = tx_sh;
    tx_load   = 1'b0;
    unique case (tx_st)
      IDLE: if (hold_full) begin
        tx_load   = 1'b1;
        tx_nx     = START;
        tx_cnt_nx = '0;
        tx_sh_nx  = hold;
      end
      START: if (tx_cnt == LAST) begin
        tx_nx     = DATA;
        tx_cnt_nx = '0;
        tx_bit_nx = '0;
      end else tx_cnt_nx = tx_cnt + 1'b1;
      DATA: if (tx_cnt == LAST) begin
        tx_cnt_nx = '0;
        tx_sh_nx  = tx_sh >> 1;
        if (tx_bit == 3'd7) tx_nx = STOP;
        else tx_bit_nx = tx_bit + 1'b1;
      end else tx_cnt_nx = tx_cnt + 1'b1;
      STOP: if (tx_cnt == LAST) begin
        tx_cnt_nx = '0;
        if (hold_full) begin
          tx_load  = 1'b1;
          tx_nx    = START;
          tx_sh_nx = hold;
        end else tx_nx = IDLE;
      end else tx_cnt_nx = tx_cnt + 1'b1;
      default: tx_nx = IDLE;
    endcase
    txd_nx = 1'b1;
    if (tx_nx == START) txd_nx = 1'b0;
    else if (tx_nx == DATA) txd_nx = tx_sh_nx[0];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tx_st  <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      txd    <= 1'b1;
    end else begin
      tx_st  <= tx_nx;
      tx_cnt <= tx_cnt_nx;
      tx_bit <= tx_bit_nx;
      tx_sh  <= tx_sh_nx;
      txd    <= txd_nx;
    end
  end

  always_comb begin
    rx_nx     = rx_st;
    rx_cnt_nx = rx_cnt;
    rx_bit_nx = rx_bit;
    rx_sh_nx  = rx_sh;
    rx_done   = 1'b0;
    unique case (rx_st)
      IDLE: if (rx_prev && !rx_s2) begin
        rx_nx     = START;
        rx_cnt_nx = '0;
        rx_bit_nx = '0;
      end
      // a line back high at mid start bit is treated as a glitch
      START: if (rx_cnt == MID) begin
        rx_cnt_nx = '0;
        rx_nx     = rx_s2 ? IDLE : DATA;
      end else rx_cnt_nx = rx_cnt + 1'b1;
      DATA: if (rx_cnt == LAST) begin
        rx_cnt_nx = '0;
        rx_sh_nx  = {rx_s2, rx_sh[7:1]};
        if (rx_bit == 3'd7) rx_nx = STOP;
        else rx_bit_nx = rx_bit + 1'b1;
      end else rx_cnt_nx = rx_cnt + 1'b1;
      STOP: if (rx_cnt == LAST) begin
        rx_nx   = IDLE;
        rx_done = rx_s2;
      end else rx_cnt_nx = rx_cnt + 1'b1;
      default: rx_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_st      <= IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      data_out   <= '0;
      data_ready <= 1'b0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_st   <= rx_nx;
      rx_cnt  <= rx_cnt_nx;
      rx_bit  <= rx_bit_nx;
      rx_sh   <= rx_sh_nx;
      // a completing byte beats a read acknowledge in the same cycle
      if (rx_done) begin
        data_out   <= rx_sh;
        data_ready <= 1'b1;
      end else if (rd_rise) begin
        data_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_responder.sv
// Directed bench for uart_responder at four clocks per bit.
// Table-driven TX/RX vectors plus hand-timed corner sequences.
module tb_uart_responder;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       wrn, rdn, rxd;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe, data_ready, tbre, tsre, txd;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rd;
    logic       rdy;
    logic [7:0] out;
  } rx_vec_t;

  tx_vec_t tx_tab[4];
  rx_vec_t rx_tab[4];
  logic    txq[100];
  logic    tsq[100];

  uart_responder #(.CLKS_PER_BIT(4)) dut (
    .Clk(Clk), .Rst(Rst), .wrn(wrn), .rdn(rdn),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
    .rxd(rxd), .txd(txd)
  );

  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", nm, act, exp);
    end
  endtask

  task automatic chk10(input string nm, input logic [9:0] act,
                       input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    data_in = b;
    wrn = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    wrn = 1'b1;
  endtask

  task automatic tx_one(input logic [7:0] b, input logic [9:0] fr);
    logic [9:0] got;
    got = '0;
    wr(b);
    @(negedge Clk);
    chk1("tbre_pre_commit", tbre, 1'b1);
    @(negedge Clk);
    chk1("tbre_held", tbre, 1'b0);
    @(negedge Clk);
    chk1("tbre_loaded", tbre, 1'b1);
    chk1("tsre_busy", tsre, 1'b0);
    chk1("txd_start", txd, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (c % 4 == 1) got[c / 4] = txd;
      if (c == 39) chk1("tsre_last_cycle", tsre, 1'b0);
    end
    chk10("tx_frame", got, fr);
    chk1("tsre_after_40", tsre, 1'b1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (4) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (4) @(negedge Clk);
    end
    rxd = stop;
    repeat (4) @(negedge Clk);
    rxd = 1'b1;
  endtask

  task automatic rd_pulse(input logic [7:0] exp);
    rdn = 1'b0;
    @(negedge Clk);
    chk1("oe_during_read", data_oe, 1'b1);
    chk8("out_during_read", data_out, exp);
    repeat (2) @(negedge Clk);
    rdn = 1'b1;
    repeat (3) @(negedge Clk);
    chk1("ready_after_read", data_ready, 1'b0);
    chk1("oe_after_read", data_oe, 1'b0);
  endtask

  initial begin
    logic [9:0] g1, g2;
    logic       ok;

    tx_tab[0] = '{8'h55, 10'b1010101010};
    tx_tab[1] = '{8'h00, 10'b1000000000};
    tx_tab[2] = '{8'hFF, 10'b1111111110};
    tx_tab[3] = '{8'hA3, 10'b1101000110};

    rx_tab[0] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h00};
    rx_tab[1] = '{8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3};
    rx_tab[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11};
    rx_tab[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22};

    Rst = 1'b0;
    wrn = 1'b1;
    rdn = 1'b1;
    rxd = 1'b1;
    data_in = 8'h00;
    repeat (3) @(negedge Clk);
    chk1("rst_txd", txd, 1'b1);
    chk1("rst_tbre", tbre, 1'b1);
    chk1("rst_tsre", tsre, 1'b1);
    chk1("rst_ready", data_ready, 1'b0);
    chk8("rst_out", data_out, 8'h00);
    chk1("rst_oe", data_oe, 1'b0);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);

    for (int i = 0; i < 4; i++) begin
      tx_one(tx_tab[i].data, tx_tab[i].frame);
      repeat (2) @(negedge Clk);
    end

    wr(8'h0F);
    repeat (3) @(negedge Clk);
    chk1("b2b_first_start", txd, 1'b0);
    fork
      begin
        for (int c = 0; c < 100; c++) begin
          txq[c] = txd;
          tsq[c] = tsre;
          @(negedge Clk);
        end
      end
      begin
        repeat (5) @(negedge Clk);
        wr(8'hF0);
        repeat (4) @(negedge Clk);
        chk1("b2b_tbre_full", tbre, 1'b0);
        wr(8'h33);
      end
    join
    for (int i = 0; i < 10; i++) begin
      g1[i] = txq[4 * i + 1];
      g2[i] = txq[40 + 4 * i + 1];
    end
    chk10("b2b_frame_0f", g1, 10'b1000011110);
    chk10("b2b_frame_f0", g2, 10'b1111100000);
    chk1("b2b_stop_end", txq[39], 1'b1);
    chk1("b2b_no_gap", txq[40], 1'b0);
    ok = 1'b1;
    for (int c = 0; c < 80; c++) if (tsq[c] !== 1'b0) ok = 1'b0;
    chk1("b2b_tsre_low_both", ok, 1'b1);
    chk1("b2b_tsre_end", tsq[80], 1'b1);
    ok = 1'b1;
    for (int c = 80; c < 100; c++) if (txq[c] !== 1'b1) ok = 1'b0;
    chk1("b2b_dropped_write_idle", ok, 1'b1);

    rxd = 1'b0;
    @(negedge Clk);
    rxd = 1'b1;
    repeat (50) @(negedge Clk);
    chk1("glitch_ready", data_ready, 1'b0);
    chk8("glitch_out", data_out, 8'h00);

    for (int i = 0; i < 4; i++) begin
      send_rx(rx_tab[i].data, rx_tab[i].stop);
      repeat (3) @(negedge Clk);
      chk1("rx_ready", data_ready, rx_tab[i].rdy);
      chk8("rx_out", data_out, rx_tab[i].out);
      if (rx_tab[i].rd) rd_pulse(rx_tab[i].out);
      repeat (4) @(negedge Clk);
    end

    fork
      send_rx(8'h33, 1'b1);
      begin
        repeat (36) @(negedge Clk);
        rdn = 1'b0;
        @(negedge Clk);
        chk1("coll_oe", data_oe, 1'b1);
        chk8("coll_out_stable", data_out, 8'h22);
        repeat (2) @(negedge Clk);
        rdn = 1'b1;
      end
    join
    repeat (3) @(negedge Clk);
    chk1("coll_ready", data_ready, 1'b1);
    chk8("coll_out", data_out, 8'h33);
    repeat (4) @(negedge Clk);

    wr(8'h55);
    rxd = 1'b0;
    repeat (14) @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk1("midrst_txd", txd, 1'b1);
    chk1("midrst_tbre", tbre, 1'b1);
    chk1("midrst_tsre", tsre, 1'b1);
    chk1("midrst_ready", data_ready, 1'b0);
    chk8("midrst_out", data_out, 8'h00);
    @(negedge Clk);
    rxd = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    repeat (4) @(negedge Clk);
    chk1("post_rst_ready", data_ready, 1'b0);
    tx_one(8'h55, 10'b1010101010);

    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
